// File: rtl/score_counter_pkg.sv
// Shared game definitions for the score counter: FSM state encoding and BCD layout.
package score_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HELD      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_e;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 3;
    localparam int BCD_W       = BCD_DIGIT_W * BCD_DIGITS;

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bcd_inc3.sv
// Three-digit BCD +1 with a ripple carry; 999 wraps to 000 (never reached with an 8-bit score).
module bcd_inc3
    import score_counter_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [BCD_W-1:0] bcd_o
);

    logic [BCD_DIGITS-1:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
        logic [BCD_DIGIT_W-1:0] dig;
        logic                   at_nine;

        assign dig     = bcd_i[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        assign at_nine = (dig == 4'd9);
        assign bcd_o[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
            !carry[i] ? dig : (at_nine ? 4'd0 : dig + 4'd1);

        if (i < BCD_DIGITS - 1) begin : g_carry
            assign carry[i+1] = carry[i] & at_nine;
        end
    end

endmodule

// File: rtl/score_counter.sv
// Frame-paced score counter: hold-to-score FSM with saturating binary/BCD score and high score.
module score_counter
    import score_counter_pkg::*;
#(
    parameter int HOLD_FRAMES = 8,
    parameter int MAX_SCORE   = 255
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_frame_tick,
    input  logic         i_move,
    input  logic         i_collision,
    input  logic         i_restart,
    output logic [7:0]   o_score,
    output logic [11:0]  o_bcd,
    output logic [7:0]   o_high_score,
    output logic         o_game_over,
    output logic         o_score_tick
);

    localparam int                HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [7:0]        SCORE_MAX = 8'(MAX_SCORE);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [7:0]          score_q, score_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_inc;
    logic [7:0]          high_q, high_d;
    logic                tick_q, tick_d;
    logic                game_over_q, game_over_d;
    logic                move_meta_q, move_sync_q;
    logic                inc;

    bcd_inc3 u_bcd_inc (
        .bcd_i (bcd_q),
        .bcd_o (bcd_inc)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        score_d     = score_q;
        bcd_d       = bcd_q;
        high_d      = high_q;
        tick_d      = 1'b0;
        inc         = 1'b0;

        // Collision is checked first so it beats a coincident incrementing tick.
        case (state_q)
            ST_IDLE: begin
                if (i_collision) begin
                    state_d = ST_GAME_OVER;
                end else if (i_frame_tick && move_sync_q) begin
                    state_d = ST_HELD;
                    hold_d  = '0;
                    inc     = 1'b1;
                end
            end
            ST_HELD: begin
                if (i_collision) begin
                    state_d = ST_GAME_OVER;
                end else if (i_frame_tick) begin
                    if (!move_sync_q) begin
                        state_d = ST_IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        inc    = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                if (i_restart) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    score_d = '0;
                    bcd_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Binary and BCD move together so the two views never disagree.
        if (inc && (score_q < SCORE_MAX)) begin
            score_d = score_q + 8'd1;
            bcd_d   = bcd_inc;
            tick_d  = 1'b1;
        end

        if ((state_d == ST_GAME_OVER) && (state_q != ST_GAME_OVER)) begin
            high_d = max8(high_q, score_q);
        end

        game_over_d = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            score_q     <= '0;
            bcd_q       <= '0;
            high_q      <= '0;
            tick_q      <= 1'b0;
            game_over_q <= 1'b0;
            move_meta_q <= 1'b0;
            move_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            score_q     <= score_d;
            bcd_q       <= bcd_d;
            high_q      <= high_d;
            tick_q      <= tick_d;
            game_over_q <= game_over_d;
            move_meta_q <= i_move;
            move_sync_q <= move_meta_q;
        end
    end

    assign o_score      = score_q;
    assign o_bcd        = bcd_q;
    assign o_high_score = high_q;
    assign o_game_over  = game_over_q;
    assign o_score_tick = tick_q;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: hand-built vector table, directed corner sequences, random play vs a reference model.
module tb_score_counter;

    localparam int H   = 8;
    localparam int MAX = 255;

    logic        clk = 1'b0;
    logic        rst_n, ft, mv, col, rs;
    logic [7:0]  o_score, o_high_score;
    logic [11:0] o_bcd;
    logic        o_game_over, o_score_tick;

    int checks = 0;
    int errors = 0;

    // Reference model state: game rules in plain integers.
    bit m_s1, m_s2, m_held, m_go, m_tick;
    int m_hold, m_score, m_high;

    score_counter #(.HOLD_FRAMES(H), .MAX_SCORE(MAX)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_tick (ft),
        .i_move       (mv),
        .i_collision  (col),
        .i_restart    (rs),
        .o_score      (o_score),
        .o_bcd        (o_bcd),
        .o_high_score (o_high_score),
        .o_game_over  (o_game_over),
        .o_score_tick (o_score_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bcd_of(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit t, input bit m, input bit c, input bit q);
        m_tick = 1'b0;
        if (!r) begin
            m_s1 = 0; m_s2 = 0; m_held = 0; m_go = 0;
            m_hold = 0; m_score = 0; m_high = 0;
        end else begin
            if (m_go) begin
                if (q) begin
                    m_go = 0; m_held = 0; m_hold = 0; m_score = 0;
                end
            end else if (c) begin
                m_go = 1;
                if (m_score > m_high) m_high = m_score;
            end else if (t) begin
                if (!m_s2) begin
                    m_held = 0;
                end else begin
                    bit bump;
                    bump = 0;
                    if (!m_held) begin
                        m_held = 1; m_hold = 0; bump = 1;
                    end else if (m_hold == H - 1) begin
                        m_hold = 0; bump = 1;
                    end else begin
                        m_hold++;
                    end
                    if (bump && m_score < MAX) begin
                        m_score++;
                        m_tick = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = m;
        end
    endtask

    // One clock: drive on the falling edge, advance model at the rising edge, compare 1 time unit later.
    task automatic step(input bit r, input bit t, input bit m, input bit c, input bit q);
        @(negedge clk);
        rst_n = r; ft = t; mv = m; col = c; rs = q;
        @(posedge clk);
        model_edge(r, t, m, c, q);
        #1;
        chk("mdl_score", 32'(o_score), 32'(m_score));
        chk("mdl_bcd",   32'(o_bcd),   32'(bcd_of(m_score)));
        chk("mdl_high",  32'(o_high_score), 32'(m_high));
        chk("mdl_go",    32'(o_game_over),  32'(m_go));
        chk("mdl_tick",  32'(o_score_tick), 32'(m_tick));
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (m_score != target && n < 4000) begin
            step(1, 1, 1, 0, 0);
            n++;
        end
        chk("run_to_reached", 32'(m_score), 32'(target));
    endtask

    typedef struct {
        bit         r, t, m, c, q;
        logic [7:0] score;
        bit         go;
        logic [7:0] high;
        bit         tick;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int pulses;
        bit rm;
        rst_n = 0; ft = 0; mv = 0; col = 0; rs = 0;

        tbl[0]  = '{0,0,0,0,0, 8'd0,0,8'd0,0};
        tbl[1]  = '{1,0,1,0,0, 8'd0,0,8'd0,0};
        tbl[2]  = '{1,0,1,0,0, 8'd0,0,8'd0,0};
        tbl[3]  = '{1,1,1,0,0, 8'd1,0,8'd0,1};
        tbl[4]  = '{1,1,1,1,0, 8'd1,1,8'd1,0};
        tbl[5]  = '{1,1,1,0,0, 8'd1,1,8'd1,0};
        tbl[6]  = '{1,0,1,0,1, 8'd0,0,8'd1,0};
        tbl[7]  = '{1,1,1,0,0, 8'd1,0,8'd1,1};
        tbl[8]  = '{1,0,0,0,0, 8'd1,0,8'd1,0};
        tbl[9]  = '{1,0,0,0,0, 8'd1,0,8'd1,0};
        tbl[10] = '{1,1,0,0,0, 8'd1,0,8'd1,0};
        tbl[11] = '{1,1,1,0,0, 8'd1,0,8'd1,0};
        tbl[12] = '{1,1,1,0,0, 8'd1,0,8'd1,0};
        tbl[13] = '{1,1,1,0,0, 8'd2,0,8'd1,1};
        tbl[14] = '{0,1,1,0,0, 8'd0,0,8'd0,0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].m, tbl[i].c, tbl[i].q);
            chk($sformatf("vec%0d_score", i), 32'(o_score), 32'(tbl[i].score));
            chk($sformatf("vec%0d_bcd", i),   32'(o_bcd),   32'(bcd_of(tbl[i].score)));
            chk($sformatf("vec%0d_go", i),    32'(o_game_over), 32'(tbl[i].go));
            chk($sformatf("vec%0d_high", i),  32'(o_high_score), 32'(tbl[i].high));
            chk($sformatf("vec%0d_tick", i),  32'(o_score_tick), 32'(tbl[i].tick));
        end

        // 17 held ticks: increments at ticks 1, 9 and 17.
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 1, 0, 0);
            pulses += int'(o_score_tick);
        end
        chk("hold17_score", 32'(o_score), 32'd3);
        chk("hold17_bcd",   32'(o_bcd),   32'h003);
        chk("hold17_pulses", 32'(pulses), 32'd3);

        // BCD carries and saturation.
        step(0, 0, 0, 0, 0);
        run_to(9);
        chk("bcd9", 32'(o_bcd), 32'h009);
        run_to(10);
        chk("bcd10_score", 32'(o_score), 32'd10);
        chk("bcd10", 32'(o_bcd), 32'h010);
        run_to(99);
        chk("bcd99", 32'(o_bcd), 32'h099);
        run_to(100);
        chk("bcd100", 32'(o_bcd), 32'h100);
        run_to(255);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            step(1, 1, 1, 0, 0);
            pulses += int'(o_score_tick);
        end
        chk("sat_score", 32'(o_score), 32'd255);
        chk("sat_bcd",   32'(o_bcd),   32'h255);
        chk("sat_pulses", 32'(pulses), 32'd0);

        // Collision coincident with an incrementing tick at 42.
        step(0, 0, 0, 0, 0);
        run_to(42);
        for (int i = 0; i < H - 1; i++) step(1, 1, 1, 0, 0);
        chk("pre_col_score", 32'(o_score), 32'd42);
        step(1, 1, 1, 1, 0);
        chk("col_score", 32'(o_score), 32'd42);
        chk("col_go",    32'(o_game_over), 32'd1);
        chk("col_high",  32'(o_high_score), 32'd42);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0);
        chk("go_frozen", 32'(o_score), 32'd42);

        // Restart keeps the high score; a lower game does not replace it.
        step(1, 0, 1, 0, 1);
        chk("rst_score", 32'(o_score), 32'd0);
        chk("rst_bcd",   32'(o_bcd),   32'h000);
        chk("rst_go",    32'(o_game_over), 32'd0);
        chk("rst_high",  32'(o_high_score), 32'd42);
        run_to(30);
        step(1, 0, 1, 1, 0);
        chk("low_game_high", 32'(o_high_score), 32'd42);
        chk("low_game_go",   32'(o_game_over), 32'd1);

        // Reset mid-hold, then move toggling without frame ticks.
        step(0, 0, 0, 0, 0);
        run_to(17);
        step(1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        chk("midrst_score", 32'(o_score), 32'd0);
        chk("midrst_bcd",   32'(o_bcd),   32'h000);
        chk("midrst_high",  32'(o_high_score), 32'd0);
        chk("midrst_go",    32'(o_game_over), 32'd0);
        chk("midrst_tick",  32'(o_score_tick), 32'd0);
        for (int i = 0; i < 12; i++) step(1, 0, i[0], 0, 0);
        chk("toggle_no_tick", 32'(o_score), 32'd0);

        // Random play against the model.
        rm = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) rm = ~rm;
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 1) == 1,
                 rm,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 8: frame ticks between successive increments while move is held.
REQ-002 SHALL have parameter MAX_SCORE, default 255: saturation value of the score.
REQ-003 SHALL have port i_clk, input, 1 bit: rising-edge system clock.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_frame_tick, input, 1 bit: single-cycle pulse once per video frame.
REQ-006 SHALL have port i_move, input, 1 bit: raw asynchronous move-button level, high = pressed.
REQ-007 SHALL have port i_collision, input, 1 bit: single-cycle game-over event.
REQ-008 SHALL have port i_restart, input, 1 bit: single-cycle restart request.
REQ-009 SHALL have port o_score, output, 8 bits: current binary score, consumed by the score renderer.
REQ-010 SHALL have port o_bcd, output, 12 bits: current score as BCD, hundreds [11:8], tens [7:4], ones [3:0].
REQ-011 SHALL have port o_high_score, output, 8 bits: best score since reset.
REQ-012 SHALL have port o_game_over, output, 1 bit: high while in GAME_OVER.
REQ-013 SHALL have port o_score_tick, output, 1 bit: one-cycle pulse in the cycle after each increment is committed.

Function
REQ-014 SHALL pass i_move through a two-flop synchronizer; only the synchronized level is used further.
REQ-015 SHALL sample the synchronized move level only on cycles with i_frame_tick=1.
REQ-016 SHALL implement states IDLE, HELD, GAME_OVER.
REQ-017 In IDLE, a frame tick with move=1 SHALL go to HELD, increment the score once, and clear the hold counter.
REQ-018 In HELD, a frame tick with move=1 SHALL advance the hold counter; when it reaches HOLD_FRAMES-1 it SHALL wrap to 0 and increment the score.
REQ-019 In HELD, a frame tick with move=0 SHALL go to IDLE with no increment.
REQ-020 Non-tick cycles SHALL NOT change state, score or hold counter, except for collision and restart.
REQ-021 o_score and o_bcd SHALL update in the cycle after the sampling frame tick, and SHALL always represent the same value.
REQ-022 The BCD increment SHALL ripple: a digit at 9 becomes 0 and carries into the next digit. Division and modulo operators SHALL NOT be used.
REQ-023 When o_score equals MAX_SCORE, further increments SHALL be suppressed, and o_score_tick SHALL NOT pulse for them.
REQ-024 i_collision in IDLE or HELD SHALL enter GAME_OVER on the next cycle and freeze o_score/o_bcd.
REQ-025 On entry to GAME_OVER, o_high_score SHALL become max(o_high_score, o_score).
REQ-026 When i_collision and an incrementing frame tick coincide, collision SHALL win: no increment.
REQ-027 i_collision SHALL be ignored in GAME_OVER.
REQ-028 i_restart SHALL be ignored outside GAME_OVER.
REQ-029 i_restart in GAME_OVER SHALL go to IDLE next cycle, clearing o_score, o_bcd and the hold counter, and retaining o_high_score.
REQ-030 After restart, a button still held SHALL re-enter HELD on the next frame tick with move=1, per REQ-017.

Reset
REQ-031 While i_rst_n=0 at a clock edge, state SHALL be IDLE, o_score=0, o_bcd=12'h000, o_high_score=0, o_game_over=0, o_score_tick=0, hold counter=0, synchronizer flops=0.
REQ-032 Reset asserted mid-hold or in GAME_OVER SHALL override all other inputs in that cycle.

Structure
REQ-033 State encodings and the BCD digit width SHALL reside in the shared game package; HOLD_FRAMES and MAX_SCORE SHALL remain module parameters.
REQ-034 The BCD ripple incrementer SHALL be one sub-module, bcd_inc3, which is purely combinational with a 12-bit input, a 12-bit output and no state.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Reset, then move=1 held through 17 frame ticks with HOLD_FRAMES=8 -> o_score=3, o_bcd=12'h003, three o_score_tick pulses.
REQ-037 Preload the score to 9, then one increment -> o_score=10, o_bcd=12'h010; preload to 99, then one increment -> o_bcd=12'h100.
REQ-038 Drive the score to 255, then hold move for 32 more ticks -> o_score stays 255, o_bcd=12'h255, no o_score_tick.
REQ-039 Score 42: collision coincident with an incrementing frame tick -> o_score=42, o_game_over=1, o_high_score=42; a subsequent move is ignored.
REQ-040 In GAME_OVER with high score 42, assert restart -> o_score=0, o_bcd=0, o_game_over=0, o_high_score=42; then reach 30 and collide -> o_high_score stays 42.
REQ-041 Assert i_rst_n=0 mid-hold at score 17 -> all outputs 0 on the next edge; move toggled between frame ticks -> no score change.
